// File: rtl/program_loader.sv
// program_loader: assembles a framed little-endian byte image into 32-bit words,
// writes them into the processor load port, then starts it and waits for end_signal.
module program_loader #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] new_instruction,
    output logic        add_into,
    output logic        load_valid,
    output logic        start_signal,
    input  logic        end_signal,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_INSTR, S_DATA, S_RUN, S_FIN, S_ERR} state_t;
    localparam logic [15:0] IMAX = 16'(IMEM_DEPTH);
    localparam logic [15:0] DMAX = 16'(DMEM_DEPTH);
    state_t      r_state, w_next;
    logic [1:0]  r_bcnt;
    logic [31:0] r_word;
    logic [15:0] r_nd, r_cnt;
    logic [31:0] r_new;
    logic        r_add, r_lv, r_start, r_done, r_err;
    logic [31:0] w_word;
    logic        w_acc, w_last, w_seg;
    assign w_seg      = r_state == S_INSTR || r_state == S_DATA;
    assign byte_ready = (r_state == S_HDR || w_seg) && !r_lv;
    assign w_acc      = byte_valid && byte_ready;
    assign w_last     = w_acc && r_bcnt == 2'd3;
    assign w_word     = {byte_in, r_word[31:8]};
    assign new_instruction = r_new;
    assign add_into        = r_add;
    assign load_valid      = r_lv;
    assign start_signal    = r_start;
    assign done            = r_done;
    assign error           = r_err;
    // Segment exits are taken in the strobe cycle, so RUN starts after the final load_valid
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_HDR;
            S_HDR:   if (w_last)
                         w_next = (w_word[15:0] > IMAX || w_word[31:16] > DMAX) ? S_ERR :
                                  w_word[15:0] != '0 ? S_INSTR :
                                  w_word[31:16] != '0 ? S_DATA : S_RUN;
            S_INSTR: if (r_lv && r_cnt == '0) w_next = r_nd != '0 ? S_DATA : S_RUN;
            S_DATA:  if (r_lv && r_cnt == '0) w_next = S_RUN;
            S_RUN:   if (end_signal) w_next = S_FIN;
            default: w_next = r_state;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_word  <= '0;
            r_nd    <= '0;
            r_cnt   <= '0;
            r_new   <= '0;
            r_add   <= 1'b0;
            r_lv    <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_lv    <= 1'b0;
            if (w_acc) begin
                r_word <= w_word;
                r_bcnt <= r_bcnt + 2'd1;
            end
            if (r_state == S_HDR && w_last) begin
                r_nd  <= w_word[31:16];
                r_cnt <= w_word[15:0] != '0 ? w_word[15:0] : w_word[31:16];
            end
            if (w_seg && w_last) begin
                r_new <= w_word;
                r_lv  <= 1'b1;
                r_cnt <= r_cnt - 16'd1;
                if (r_state == S_DATA) r_add <= 1'b1;
            end
            if (r_state == S_INSTR && w_next == S_DATA) r_cnt <= r_nd;
            if (w_next == S_RUN) r_start <= 1'b1;
            if (w_next == S_FIN) r_done <= 1'b1;
            if (w_next == S_ERR) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader; expected words are queued
// as the image is driven and popped on each load_valid strobe.
`timescale 1ns/100ps
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] new_instruction;
    logic        add_into, load_valid, start_signal, done, error;
    logic        end_signal = 1'b0;
    int n_chk = 0, n_pass = 0, n_lv = 0;
    logic [32:0] q[$];
    logic [31:0] img[3] = '{32'h0000_0013, 32'h0010_0093, 32'hDEAD_BEEF};

    program_loader dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .new_instruction(new_instruction), .add_into(add_into),
        .load_valid(load_valid), .start_signal(start_signal), .end_signal(end_signal),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    always @(negedge clk) begin
        if (reset && load_valid) begin
            n_lv++;
            chk("ready_at_strobe", 64'(byte_ready), 64'd0);
            if (q.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
            else chk("word", 64'({add_into, new_instruction}), 64'(q.pop_front()));
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat ($urandom_range(gap, 0)) @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("byte_timeout", 64'd0, 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] ni, input logic [15:0] nd, input int gap);
        send_byte(ni[7:0], gap);
        send_byte(ni[15:8], gap);
        send_byte(nd[7:0], gap);
        send_byte(nd[15:8], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
        chk("latency", 64'(load_valid), 64'd1);
    endtask

    task automatic send_image(input int ni, input int nd, input int gap);
        for (int i = 0; i < ni + nd; i++) q.push_back({i >= ni, img[i]});
        send_hdr(16'(ni), 16'(nd), gap);
        for (int i = 0; i < ni + nd; i++) send_word(img[i], gap);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!start_signal && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("start", 64'(start_signal), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        byte_valid = 1'b0;
        end_signal = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        chk("rst_outputs", 64'({byte_ready, new_instruction, add_into, load_valid,
                                start_signal, done, error}), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("hdr_ready", 64'(byte_ready), 64'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lv0;
        // gapless 2+1 image, then end_signal 50 cycles into RUN
        do_reset();
        send_image(2, 1, 0);
        wait_start();
        chk("strobes_a", 64'(n_lv), 64'd3);
        chk("queue_a", 64'(q.size()), 64'd0);
        chk("add_into_held", 64'(add_into), 64'd1);
        chk("run_ready", 64'(byte_ready), 64'd0);
        repeat (49) @(negedge clk);
        chk("done_early", 64'(done), 64'd0);
        end_signal = 1'b1;
        @(negedge clk);
        end_signal = 1'b0;
        chk("done", 64'(done), 64'd1);
        chk("start_held", 64'(start_signal), 64'd1);
        repeat (5) @(negedge clk);
        chk("done_held", 64'({done, start_signal}), 64'b11);
        // same image with random gaps; end_signal outside RUN is ignored
        do_reset();
        end_signal = 1'b1;
        @(negedge clk);
        end_signal = 1'b0;
        lv0 = n_lv;
        send_image(2, 1, 7);
        wait_start();
        chk("strobes_b", 64'(n_lv - lv0), 64'd3);
        chk("queue_b", 64'(q.size()), 64'd0);
        chk("no_early_done", 64'(done), 64'd0);
        // empty image goes straight to RUN
        do_reset();
        lv0 = n_lv;
        send_hdr(16'd0, 16'd0, 0);
        chk("empty_start", 64'(start_signal), 64'd1);
        repeat (3) @(negedge clk);
        chk("empty_no_strobe", 64'(n_lv - lv0), 64'd0);
        // data-only image: add_into goes high on the first data strobe
        do_reset();
        for (int i = 0; i < 2; i++) q.push_back({1'b1, img[i]});
        send_hdr(16'd0, 16'd2, 0);
        chk("dataonly_add_pre", 64'(add_into), 64'd0);
        for (int i = 0; i < 2; i++) send_word(img[i], 0);
        wait_start();
        chk("queue_d", 64'(q.size()), 64'd0);
        // header counts beyond depth
        do_reset();
        send_hdr(16'd257, 16'd0, 0);
        chk("err_ni", 64'({error, byte_ready, start_signal}), 64'b100);
        repeat (4) @(negedge clk);
        chk("err_held", 64'({error, start_signal}), 64'b10);
        do_reset();
        send_hdr(16'd1, 16'd257, 0);
        chk("err_nd", 64'({error, byte_ready, start_signal}), 64'b100);
        // reset pulse mid-INSTR, then a fresh load
        do_reset();
        send_hdr(16'd2, 16'd1, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        #2;
        reset = 1'b0;
        #0.5;
        chk("async_rst", 64'({byte_ready, new_instruction, add_into, load_valid,
                              start_signal, done, error}), 64'd0);
        #0.5;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_ready", 64'(byte_ready), 64'd1);
        lv0 = n_lv;
        send_image(2, 1, 0);
        wait_start();
        chk("strobes_e", 64'(n_lv - lv0), 64'd3);
        chk("queue_e", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
